// File: rtl/hilo_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_mdu_ctrl_pkg
// Brief   : Operation codes, FSM state codes and op-class helpers shared by
//           the HI/LO multiply/divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_mdu_ctrl_pkg;

    // HI/LO operation codes presented by EX
    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    // Sequencer state codes
    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_MUL  = 2'd1;
    localparam logic [1:0] MDU_DIV  = 2'd2;
    localparam logic [1:0] MDU_DONE = 2'd3;

    // Multiplies and divides are the multi-cycle ops that hold the pipeline
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op <= MDU_OP_DIVU);
    endfunction

    // Codes 6 and 7 are not HI/LO ops and are never accepted
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op <= MDU_OP_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mdu_ctrl_div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division iteration. Shifts the {rem,quo} pair left
//           by one, trial-subtracts the divisor from the partial remainder
//           and shifts the resulting quotient bit in at the bottom.
// Revision: 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] rq_in,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] rq_out
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // Partial remainder needs one extra bit after the shift so the compare
    // against the divisor cannot wrap.
    always_comb begin
        shifted = rq_in[2*DATA_W-1:DATA_W-1];
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[DATA_W-1:0] - divisor;
        rq_out  = {(fits ? diff : shifted[DATA_W-1:0]),
                   rq_in[DATA_W-2:0], fits};
    end

endmodule
`default_nettype wire

// File: rtl/hilo_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_mdu_ctrl
// Brief   : HI/LO sequencer between EX and the HI/LO register file. Runs a
//           pipelined multiply or a DATA_W-step restoring divide, stalls the
//           pipeline while busy and issues one-cycle HI/LO write strobes.
// Revision: 1.0 - initial release
// ============================================================================
import hilo_mdu_ctrl_pkg::*;

module hilo_mdu_ctrl #(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              stall,
    output logic              writeHi,
    output logic              writeLo,
    output logic [DATA_W-1:0] hi_data_out,
    output logic [DATA_W-1:0] lo_data_out
);

    localparam int CNT_MAX = (DATA_W > MUL_LATENCY) ? DATA_W : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    count;
    logic [2:0]          op_q;
    // Multiply: quo_q = multiplicand, dsr_q = multiplier.
    // Divide:   {rem_q,quo_q} = working pair, dsr_q = |divisor|.
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dsr_q;
    logic                sign_a;
    logic                sign_b;
    logic [2*DATA_W-1:0] rq_next;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                src_signed;

    // Full-width product; operands are extended to 2*DATA_W so the low half
    // of an unsigned multiply is the correct two's-complement result.
    function automatic logic [2*DATA_W-1:0] mul_prod(
        input logic              is_signed,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] ea;
        logic [2*DATA_W-1:0] eb;
        ea = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
        eb = {{DATA_W{is_signed & b[DATA_W-1]}}, b};
        return ea * eb;
    endfunction

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rq_in   ({rem_q, quo_q}),
        .divisor (dsr_q),
        .rq_out  (rq_next)
    );

    // Sign fixup of the final iteration: quotient follows sa^sb, remainder
    // follows the dividend.
    always_comb begin
        src_signed = (op == MDU_OP_DIV);
        quo_fix    = (sign_a ^ sign_b) ? -rq_next[DATA_W-1:0] : rq_next[DATA_W-1:0];
        rem_fix    = sign_a ? -rq_next[2*DATA_W-1:DATA_W] : rq_next[2*DATA_W-1:DATA_W];
    end

    // Hold IF..EX from the accept cycle of a mul/div until the result cycle.
    always_comb begin
        stall = 1'b0;
        if (!flush) begin
            if (state == MDU_IDLE)
                stall = start && is_muldiv(op);
            else if (state == MDU_MUL || state == MDU_DIV)
                stall = 1'b1;
        end
    end

    assign writeHi = (state == MDU_DONE) && !flush && (op_q != MDU_OP_MTLO);
    assign writeLo = (state == MDU_DONE) && !flush && (op_q != MDU_OP_MTHI);

    // Sequencer: accept, iterate, load result registers on the last step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= MDU_IDLE;
            count       <= '0;
            op_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            hi_data_out <= '0;
            lo_data_out <= '0;
        end else if (flush) begin
            state <= MDU_IDLE;
            count <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start && is_valid_op(op)) begin
                        op_q <= op;
                        if (op == MDU_OP_MTHI) begin
                            hi_data_out <= src_a;
                            state       <= MDU_DONE;
                        end else if (op == MDU_OP_MTLO) begin
                            lo_data_out <= src_a;
                            state       <= MDU_DONE;
                        end else if (op == MDU_OP_MULT || op == MDU_OP_MULTU) begin
                            quo_q <= src_a;
                            dsr_q <= src_b;
                            if (MUL_LATENCY <= 1) begin
                                {hi_data_out, lo_data_out} <=
                                    mul_prod(op == MDU_OP_MULT, src_a, src_b);
                                state <= MDU_DONE;
                            end else begin
                                count <= CNT_W'(MUL_LATENCY - 1);
                                state <= MDU_MUL;
                            end
                        end else begin
                            sign_a <= src_signed & src_a[DATA_W-1];
                            sign_b <= src_signed & src_b[DATA_W-1];
                            rem_q  <= '0;
                            quo_q  <= (src_signed & src_a[DATA_W-1]) ? -src_a : src_a;
                            dsr_q  <= (src_signed & src_b[DATA_W-1]) ? -src_b : src_b;
                            count  <= CNT_W'(DATA_W);
                            state  <= MDU_DIV;
                        end
                    end
                end
                MDU_MUL: begin
                    if (count == CNT_W'(1)) begin
                        {hi_data_out, lo_data_out} <=
                            mul_prod(op_q == MDU_OP_MULT, quo_q, dsr_q);
                        count <= '0;
                        state <= MDU_DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                MDU_DIV: begin
                    {rem_q, quo_q} <= rq_next;
                    if (count == CNT_W'(1)) begin
                        hi_data_out <= rem_fix;
                        lo_data_out <= quo_fix;
                        count       <= '0;
                        state       <= MDU_DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_mdu_ctrl
// Brief   : Self-checking bench for hilo_mdu_ctrl: directed cases plus random
//           ops compared against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_mdu_ctrl;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] hi_data_out;
    logic [31:0] lo_data_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    hilo_mdu_ctrl #(
        .DATA_W      (DATA_W),
        .MUL_LATENCY (MUL_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .stall       (stall),
        .writeHi     (writeHi),
        .writeLo     (writeLo),
        .hi_data_out (hi_data_out),
        .lo_data_out (lo_data_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result of each op, from plain integer arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        eh = model_hi;
        el = model_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = 64'(sa * sb); {eh, el} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; end
            3'd2: begin
                if (b == 0) begin el = a[31] ? 32'd1 : 32'hFFFF_FFFF; eh = a; end
                else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
            end
            3'd3: begin
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
            3'd4: eh = a;
            default: el = a;
        endcase
    endtask

    // Issue one op in the current idle cycle and follow it to completion.
    // fl = cycle offset of a flush pulse (0 = with start), or -1 for none.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int fl);
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
        bit          md;
        model(o, a, b, eh, el);
        md  = (o <= 3'd3);
        lat = (o <= 3'd1) ? MUL_LAT : (md ? DATA_W + 1 : 1);
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b; flush = (fl == 0);
        #1;
        chk("stall_accept", 64'(stall), 64'(md && fl != 0));
        chk("strobe_accept", 64'({writeHi, writeLo}), 64'd0);
        chk("hold_accept", {hi_data_out, lo_data_out}, {model_hi, model_lo});
        if (fl == 0) return;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom);
            src_a = $urandom;
            src_b = $urandom;
            flush = (k == fl);
            #1;
            if (k == fl) begin
                chk("stall_flush", 64'(stall), 64'd0);
                chk("strobe_flush", 64'({writeHi, writeLo}), 64'd0);
                return;
            end else if (k < lat) begin
                chk("stall_busy", 64'(stall), 64'(md));
                chk("strobe_busy", 64'({writeHi, writeLo}), 64'd0);
                chk("hold_busy", {hi_data_out, lo_data_out}, {model_hi, model_lo});
            end else begin
                model_hi = eh;
                model_lo = el;
                chk("stall_done", 64'(stall), 64'd0);
                chk("writeHi", 64'(writeHi), 64'(o != 3'd5));
                chk("writeLo", 64'(writeLo), 64'(o != 3'd4));
                chk("hi_data", 64'(hi_data_out), 64'(model_hi));
                chk("lo_data", 64'(lo_data_out), 64'(model_lo));
            end
        end
    endtask

    initial begin
        // Reset held for a few edges
        repeat (3) @(negedge clock);
        #1;
        chk("reset_out", {29'd0, stall, writeHi, writeLo, hi_data_out, lo_data_out}, 64'd0);
        reset = 1'b1;

        // Directed cases
        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1);
        chk("mult_hi", 64'(hi_data_out), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_data_out), 64'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("multu_hilo", {hi_data_out, lo_data_out}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        chk("div_hilo", {hi_data_out, lo_data_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'h0000_000A, 32'h0, -1);
        chk("divu_zero", {hi_data_out, lo_data_out}, 64'h0000_000A_FFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_ovf", {hi_data_out, lo_data_out}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'hFFFF_FFF0, 32'h0, -1);
        run_op(3'd3, 32'h1234_5678, 32'h0000_0100, 10);
        run_op(3'd5, 32'hCAFE_F00D, 32'h0, -1);
        run_op(3'd4, 32'h5555_AAAA, 32'h0, 0);

        // Synchronous reset in the middle of a multiply
        @(negedge clock);
        start = 1'b1; op = 3'd0; src_a = 32'h7; src_b = 32'h9; flush = 1'b0;
        @(negedge clock);
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_mid", {29'd0, stall, writeHi, writeLo, hi_data_out, lo_data_out}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        run_op(3'd4, 32'h1234_5678, 32'h0, -1);
        chk("mthi_lo_kept", {hi_data_out, lo_data_out}, 64'h1234_5678_0000_0000);

        // Random back-to-back ops, occasionally flushed before the write cycle
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          rl;
            int          rf;
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            rl = (ro <= 3'd1) ? MUL_LAT : (ro <= 3'd3 ? DATA_W + 1 : 1);
            rf = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rl - 1) : -1;
            run_op(ro, ra, rb, rf);
        end

        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("idle_end", 64'({stall, writeHi, writeLo}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
